ace_dispatch_credit: RTL and testbench

Parametrised, credit-based dispatch gate for a WIDTH-wide in-order dispatch stage. It holds registered occupancy counters for the ROB, both reservation stations (RS0: complex/branch; RS1: simple/memory), the LDQ and the STQ. Each cycle it dispatches the longest in-order prefix of the incoming group that fits, so a group can be partially dispatched instead of stalling whole. It sits between rename and the ROB/RS/LSQ write ports and drives their write enables and the frontend stall.

---
 rtl/ace_dispatch_credit.sv | 225 ++++++++++++++++++++++
 tb/tb_ace_dispatch_credit.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_dispatch_credit.sv
// ---------------------------------------------------------------------------
// ace_dispatch_credit
//
// Credit-based dispatch gate for a WIDTH-wide in-order dispatch stage.
// Keeps registered occupancy counters for the ROB, RS0 (complex/branch),
// RS1 (simple/memory), the load queue and the store queue. Each cycle the
// longest in-order prefix of the incoming group that fits in the free space
// of every resource is dispatched. The rest of the group is held by raising
// the frontend stall.
//
// Ports
//   clock, reset             clock, asynchronous active-high reset
//   stall_i                  downstream hold, nothing dispatches
//   flush_i                  backend flush, all counters clear next edge
//   inst_vld_i[WIDTH]        slot valid, slot 0 is oldest
//   inst_rs1_i[WIDTH]        1 = RS1, 0 = RS0
//   inst_ld_i / inst_st_i    slot also takes an LDQ / STQ entry
//   *_rel_i[RLS_W]           entries released this cycle, per resource
//   dispatch_mask_o          slots dispatched this cycle (combinational)
//   dispatch_num_o           popcount of dispatch_mask_o
//   dispatch_frontend_stl_o  a valid slot was not dispatched
//   *_cnt_o                  registered occupancy per resource
//   credit_err_o             sticky release-underflow flag
// ---------------------------------------------------------------------------
module ace_dispatch_credit #(
    parameter int WIDTH     = 4,
    parameter int ROB_DEPTH = 32,
    parameter int RS0_DEPTH = 16,
    parameter int RS1_DEPTH = 16,
    parameter int LDQ_DEPTH = 8,
    parameter int STQ_DEPTH = 8,
    parameter int RLS_W     = $clog2(WIDTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic [WIDTH-1:0]               inst_vld_i,
    input  logic [WIDTH-1:0]               inst_rs1_i,
    input  logic [WIDTH-1:0]               inst_ld_i,
    input  logic [WIDTH-1:0]               inst_st_i,
    input  logic [RLS_W-1:0]               rob_rel_i,
    input  logic [RLS_W-1:0]               rs0_rel_i,
    input  logic [RLS_W-1:0]               rs1_rel_i,
    input  logic [RLS_W-1:0]               ldq_rel_i,
    input  logic [RLS_W-1:0]               stq_rel_i,
    output logic [WIDTH-1:0]               dispatch_mask_o,
    output logic [RLS_W-1:0]               dispatch_num_o,
    output logic                           dispatch_frontend_stl_o,
    output logic [$clog2(ROB_DEPTH+1)-1:0] rob_cnt_o,
    output logic [$clog2(RS0_DEPTH+1)-1:0] rs0_cnt_o,
    output logic [$clog2(RS1_DEPTH+1)-1:0] rs1_cnt_o,
    output logic [$clog2(LDQ_DEPTH+1)-1:0] ldq_cnt_o,
    output logic [$clog2(STQ_DEPTH+1)-1:0] stq_cnt_o,
    output logic                           credit_err_o
);

    localparam int ROB_CW = $clog2(ROB_DEPTH + 1);
    localparam int RS0_CW = $clog2(RS0_DEPTH + 1);
    localparam int RS1_CW = $clog2(RS1_DEPTH + 1);
    localparam int LDQ_CW = $clog2(LDQ_DEPTH + 1);
    localparam int STQ_CW = $clog2(STQ_DEPTH + 1);

    // Occupancy registers
    logic [ROB_CW-1:0] r_rob_cnt;
    logic [RS0_CW-1:0] r_rs0_cnt;
    logic [RS1_CW-1:0] r_rs1_cnt;
    logic [LDQ_CW-1:0] r_ldq_cnt;
    logic [STQ_CW-1:0] r_stq_cnt;
    logic              r_credit_err;

    // Free space per resource, from registered counts only
    logic [31:0] w_free_rob;
    logic [31:0] w_free_rs0;
    logic [31:0] w_free_rs1;
    logic [31:0] w_free_ldq;
    logic [31:0] w_free_stq;

    // Running cumulative demand of slots 0..i while scanning the group
    logic [31:0] w_cum_rob;
    logic [31:0] w_cum_rs0;
    logic [31:0] w_cum_rs1;
    logic [31:0] w_cum_ldq;
    logic [31:0] w_cum_stq;
    logic        w_prefix_ok;

    logic [WIDTH-1:0] w_mask;

    // Demand actually consumed by the dispatched slots
    logic [31:0] w_dem_rob;
    logic [31:0] w_dem_rs0;
    logic [31:0] w_dem_rs1;
    logic [31:0] w_dem_ldq;
    logic [31:0] w_dem_stq;

    // {underflow, next value} per resource
    logic [32:0] w_nxt_rob;
    logic [32:0] w_nxt_rs0;
    logic [32:0] w_nxt_rs1;
    logic [32:0] w_nxt_ldq;
    logic [32:0] w_nxt_stq;
    logic        w_underflow;

    // Loads win over stores when both flags are set on one slot
    logic [WIDTH-1:0] w_st_only;

    function automatic logic [31:0] popcnt(input logic [WIDTH-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // cnt + demand - release, clamped at zero with an underflow indication
    // in the top bit. Counts never exceed their depth, so no upper clamp.
    function automatic logic [32:0] credit_next(input logic [31:0] cnt,
                                                input logic [31:0] dem,
                                                input logic [31:0] rel);
        logic [31:0] sum;
        sum = cnt + dem;
        if (rel > sum) begin
            return {1'b1, 32'd0};
        end
        return {1'b0, sum - rel};
    endfunction

    assign w_st_only = inst_st_i & ~inst_ld_i;

    assign w_free_rob = 32'(ROB_DEPTH) - 32'(r_rob_cnt);
    assign w_free_rs0 = 32'(RS0_DEPTH) - 32'(r_rs0_cnt);
    assign w_free_rs1 = 32'(RS1_DEPTH) - 32'(r_rs1_cnt);
    assign w_free_ldq = 32'(LDQ_DEPTH) - 32'(r_ldq_cnt);
    assign w_free_stq = 32'(STQ_DEPTH) - 32'(r_stq_cnt);

    // Prefix scan: once a slot is invalid or does not fit, no younger slot
    // can dispatch, even if it alone would fit.
    always_comb begin
        w_mask      = '0;
        w_prefix_ok = !(reset || stall_i || flush_i);
        w_cum_rob   = '0;
        w_cum_rs0   = '0;
        w_cum_rs1   = '0;
        w_cum_ldq   = '0;
        w_cum_stq   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cum_rob = w_cum_rob + 32'd1;
            if (inst_rs1_i[i]) begin
                w_cum_rs1 = w_cum_rs1 + 32'd1;
            end else begin
                w_cum_rs0 = w_cum_rs0 + 32'd1;
            end
            if (inst_ld_i[i]) begin
                w_cum_ldq = w_cum_ldq + 32'd1;
            end else if (inst_st_i[i]) begin
                w_cum_stq = w_cum_stq + 32'd1;
            end
            if (!inst_vld_i[i]            ||
                (w_cum_rob > w_free_rob)  ||
                (w_cum_rs0 > w_free_rs0)  ||
                (w_cum_rs1 > w_free_rs1)  ||
                (w_cum_ldq > w_free_ldq)  ||
                (w_cum_stq > w_free_stq)) begin
                w_prefix_ok = 1'b0;
            end
            w_mask[i] = w_prefix_ok;
        end
    end

    assign w_dem_rob = popcnt(w_mask);
    assign w_dem_rs0 = popcnt(w_mask & ~inst_rs1_i);
    assign w_dem_rs1 = popcnt(w_mask & inst_rs1_i);
    assign w_dem_ldq = popcnt(w_mask & inst_ld_i);
    assign w_dem_stq = popcnt(w_mask & w_st_only);

    assign w_nxt_rob = credit_next(32'(r_rob_cnt), w_dem_rob, 32'(rob_rel_i));
    assign w_nxt_rs0 = credit_next(32'(r_rs0_cnt), w_dem_rs0, 32'(rs0_rel_i));
    assign w_nxt_rs1 = credit_next(32'(r_rs1_cnt), w_dem_rs1, 32'(rs1_rel_i));
    assign w_nxt_ldq = credit_next(32'(r_ldq_cnt), w_dem_ldq, 32'(ldq_rel_i));
    assign w_nxt_stq = credit_next(32'(r_stq_cnt), w_dem_stq, 32'(stq_rel_i));

    assign w_underflow = w_nxt_rob[32] | w_nxt_rs0[32] | w_nxt_rs1[32] |
                         w_nxt_ldq[32] | w_nxt_stq[32];

    // Flush discards the whole backend, so pending releases are meaningless
    // and counters simply restart from empty; the error flag survives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rob_cnt    <= '0;
            r_rs0_cnt    <= '0;
            r_rs1_cnt    <= '0;
            r_ldq_cnt    <= '0;
            r_stq_cnt    <= '0;
            r_credit_err <= 1'b0;
        end else if (flush_i) begin
            r_rob_cnt    <= '0;
            r_rs0_cnt    <= '0;
            r_rs1_cnt    <= '0;
            r_ldq_cnt    <= '0;
            r_stq_cnt    <= '0;
        end else begin
            r_rob_cnt    <= ROB_CW'(w_nxt_rob[31:0]);
            r_rs0_cnt    <= RS0_CW'(w_nxt_rs0[31:0]);
            r_rs1_cnt    <= RS1_CW'(w_nxt_rs1[31:0]);
            r_ldq_cnt    <= LDQ_CW'(w_nxt_ldq[31:0]);
            r_stq_cnt    <= STQ_CW'(w_nxt_stq[31:0]);
            r_credit_err <= r_credit_err | w_underflow;
        end
    end

    assign dispatch_mask_o = w_mask;
    assign dispatch_num_o  = RLS_W'(w_dem_rob);

    assign dispatch_frontend_stl_o = !reset && !flush_i &&
                                     (stall_i || (|(inst_vld_i & ~w_mask)));

    assign rob_cnt_o    = r_rob_cnt;
    assign rs0_cnt_o    = r_rs0_cnt;
    assign rs1_cnt_o    = r_rs1_cnt;
    assign ldq_cnt_o    = r_ldq_cnt;
    assign stq_cnt_o    = r_stq_cnt;
    assign credit_err_o = r_credit_err;

endmodule

// File: tb/tb_ace_dispatch_credit.sv
module tb_ace_dispatch_credit;

    logic       clock;
    logic       reset;
    logic       stall_i;
    logic       flush_i;
    logic [3:0] inst_vld_i;
    logic [3:0] inst_rs1_i;
    logic [3:0] inst_ld_i;
    logic [3:0] inst_st_i;
    logic [2:0] rob_rel_i;
    logic [2:0] rs0_rel_i;
    logic [2:0] rs1_rel_i;
    logic [2:0] ldq_rel_i;
    logic [2:0] stq_rel_i;
    logic [3:0] dispatch_mask_o;
    logic [2:0] dispatch_num_o;
    logic       dispatch_frontend_stl_o;
    logic [5:0] rob_cnt_o;
    logic [4:0] rs0_cnt_o;
    logic [4:0] rs1_cnt_o;
    logic [3:0] ldq_cnt_o;
    logic [3:0] stq_cnt_o;
    logic       credit_err_o;

    int tests_run = 0;
    int failed    = 0;

    // Reference state: 0 rob, 1 rs0, 2 rs1, 3 ldq, 4 stq
    int DEP [5] = '{32, 16, 16, 8, 8};
    int m_cnt [5];
    int m_err;

    typedef struct {
        logic [3:0] vld, rs1, ld, st;
        logic       stl, fl;
        logic [2:0] rrob, rrs0, rrs1, rldq, rstq;
        int         lit_mask;   // -1 when only the model is used
    } stim_t;

    ace_dispatch_credit dut (
        .clock                   (clock),
        .reset                   (reset),
        .stall_i                 (stall_i),
        .flush_i                 (flush_i),
        .inst_vld_i              (inst_vld_i),
        .inst_rs1_i              (inst_rs1_i),
        .inst_ld_i               (inst_ld_i),
        .inst_st_i               (inst_st_i),
        .rob_rel_i               (rob_rel_i),
        .rs0_rel_i               (rs0_rel_i),
        .rs1_rel_i               (rs1_rel_i),
        .ldq_rel_i               (ldq_rel_i),
        .stq_rel_i               (stq_rel_i),
        .dispatch_mask_o         (dispatch_mask_o),
        .dispatch_num_o          (dispatch_num_o),
        .dispatch_frontend_stl_o (dispatch_frontend_stl_o),
        .rob_cnt_o               (rob_cnt_o),
        .rs0_cnt_o               (rs0_cnt_o),
        .rs1_cnt_o               (rs1_cnt_o),
        .ldq_cnt_o               (ldq_cnt_o),
        .stq_cnt_o               (stq_cnt_o),
        .credit_err_o            (credit_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic stim_t mk(logic [3:0] vld, logic [3:0] rs1, logic [3:0] ld,
                                 logic [3:0] st, logic stl, logic fl,
                                 logic [2:0] rrob, logic [2:0] rrs0, logic [2:0] rrs1,
                                 logic [2:0] rldq, logic [2:0] rstq, int lit);
        stim_t s;
        s.vld = vld; s.rs1 = rs1; s.ld = ld; s.st = st; s.stl = stl; s.fl = fl;
        s.rrob = rrob; s.rrs0 = rrs0; s.rrs1 = rrs1; s.rldq = rldq; s.rstq = rstq;
        s.lit_mask = lit;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        inst_vld_i = s.vld; inst_rs1_i = s.rs1; inst_ld_i = s.ld; inst_st_i = s.st;
        stall_i = s.stl; flush_i = s.fl;
        rob_rel_i = s.rrob; rs0_rel_i = s.rrs0; rs1_rel_i = s.rrs1;
        ldq_rel_i = s.rldq; stq_rel_i = s.rstq;
    endtask

    task automatic idle();
        apply(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, -1));
    endtask

    // Oldest-first greedy fill: stop at the first slot that is invalid or
    // would overdraw any resource's free space.
    function automatic logic [3:0] model_mask();
        int need [5];
        logic [3:0] m;
        bit go;
        m = 4'h0;
        go = !(reset || stall_i || flush_i);
        need = '{default: 0};
        for (int i = 0; i < 4; i++) begin
            if (!inst_vld_i[i]) go = 0;
            need[0] += 1;
            if (inst_rs1_i[i]) need[2] += 1; else need[1] += 1;
            if (inst_ld_i[i]) need[3] += 1; else if (inst_st_i[i]) need[4] += 1;
            for (int r = 0; r < 5; r++) if (need[r] > DEP[r] - m_cnt[r]) go = 0;
            if (go) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic model_stall(input logic [3:0] m);
        if (reset || flush_i) return 1'b0;
        return stall_i || ((inst_vld_i & ~m) != 4'h0);
    endfunction

    function automatic logic [24:0] model_pack();
        return {6'(m_cnt[0]), 5'(m_cnt[1]), 5'(m_cnt[2]), 4'(m_cnt[3]),
                4'(m_cnt[4]), 1'(m_err)};
    endfunction

    function automatic logic [24:0] dut_pack();
        return {rob_cnt_o, rs0_cnt_o, rs1_cnt_o, ldq_cnt_o, stq_cnt_o, credit_err_o};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 5; r++) m_cnt[r] = 0;
        m_err = 0;
    endtask

    task automatic model_tick(input logic [3:0] m);
        int dem [5];
        int rel [5];
        int v;
        if (flush_i) begin
            for (int r = 0; r < 5; r++) m_cnt[r] = 0;
            return;
        end
        dem = '{default: 0};
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                dem[0] += 1;
                if (inst_rs1_i[i]) dem[2] += 1; else dem[1] += 1;
                if (inst_ld_i[i]) dem[3] += 1; else if (inst_st_i[i]) dem[4] += 1;
            end
        end
        rel = '{int'(rob_rel_i), int'(rs0_rel_i), int'(rs1_rel_i),
                int'(ldq_rel_i), int'(stq_rel_i)};
        for (int r = 0; r < 5; r++) begin
            v = m_cnt[r] + dem[r] - rel[r];
            if (v < 0) begin v = 0; m_err = 1; end
            m_cnt[r] = v;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(mk(4'hF, 4'hF, 4'h3, 4'h0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, -1));
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_reset();
        tests_run++;
        if (dispatch_mask_o !== 4'h0 || dispatch_frontend_stl_o !== 1'b0) begin
            failed++;
            $display("FAIL reset_outputs: mask=%b stall=%b, want 0000/0",
                     dispatch_mask_o, dispatch_frontend_stl_o);
        end
        tests_run++;
        if (dut_pack() !== 25'd0) begin
            failed++;
            $display("FAIL reset_counts: got %h want 0", dut_pack());
        end
        idle();
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_full_group();
        logic [3:0] em;
        apply(mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 15));
        @(negedge clock);
        em = model_mask();
        tests_run++;
        if (dispatch_mask_o !== 4'b1111 || dispatch_mask_o !== em) begin
            failed++;
            $display("FAIL full_group_mask: got %b want 1111", dispatch_mask_o);
        end
        tests_run++;
        if (dispatch_num_o !== 3'd4 || dispatch_frontend_stl_o !== 1'b0) begin
            failed++;
            $display("FAIL full_group_num: num=%0d stall=%b want 4/0",
                     dispatch_num_o, dispatch_frontend_stl_o);
        end
        @(posedge clock);
        model_tick(em);
        #1;
        tests_run++;
        if (rob_cnt_o !== 6'd4 || rs1_cnt_o !== 5'd4 || dut_pack() !== model_pack()) begin
            failed++;
            $display("FAIL full_group_counts: rob=%0d rs1=%0d pack=%h want 4/4 pack=%h",
                     rob_cnt_o, rs1_cnt_o, dut_pack(), model_pack());
        end
    endtask

    task automatic test_flush();
        stim_t tab [$];
        logic [3:0] em;
        tab.push_back(mk(4'hF, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, -1));
        tab.push_back(mk(4'hF, 4'h5, 4'h1, 4'h0, 1'b0, 1'b1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 0));
        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k]);
            @(negedge clock);
            em = model_mask();
            tests_run++;
            if (dispatch_mask_o !== em ||
                (tab[k].lit_mask >= 0 && dispatch_mask_o !== 4'(tab[k].lit_mask))) begin
                failed++;
                $display("FAIL flush_mask[%0d]: got %b want %b", k, dispatch_mask_o, em);
            end
            tests_run++;
            if (dispatch_frontend_stl_o !== model_stall(em) ||
                dispatch_num_o !== 3'($countones(em))) begin
                failed++;
                $display("FAIL flush_stall[%0d]: stall=%b num=%0d want %b/%0d", k,
                         dispatch_frontend_stl_o, dispatch_num_o, model_stall(em),
                         $countones(em));
            end
            @(posedge clock);
            model_tick(em);
            #1;
            tests_run++;
            if (dut_pack() !== model_pack()) begin
                failed++;
                $display("FAIL flush_counts[%0d]: got %h want %h", k, dut_pack(), model_pack());
            end
        end
        tests_run++;
        if ({rob_cnt_o, rs0_cnt_o, rs1_cnt_o, ldq_cnt_o, stq_cnt_o} !== 24'd0) begin
            failed++;
            $display("FAIL flush_zero: got %h want 0", dut_pack());
        end
    endtask

    task automatic test_ldq_partial();
        stim_t tab [$];
        int    lit_ldq [5] = '{4, 6, 6, 8, 6};
        logic [3:0] em;
        tab.push_back(mk(4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 15));
        tab.push_back(mk(4'h3, 4'hF, 4'h3, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3));
        tab.push_back(mk(4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3));
        tab.push_back(mk(4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3));
        tab.push_back(mk(4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 0));
        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k]);
            @(negedge clock);
            em = model_mask();
            tests_run++;
            if (dispatch_mask_o !== em || dispatch_mask_o !== 4'(tab[k].lit_mask)) begin
                failed++;
                $display("FAIL ldq_mask[%0d]: got %b want %b", k, dispatch_mask_o, em);
            end
            tests_run++;
            if (dispatch_frontend_stl_o !== model_stall(em)) begin
                failed++;
                $display("FAIL ldq_stall[%0d]: got %b want %b", k,
                         dispatch_frontend_stl_o, model_stall(em));
            end
            @(posedge clock);
            model_tick(em);
            #1;
            tests_run++;
            if (dut_pack() !== model_pack() || ldq_cnt_o !== 4'(lit_ldq[k])) begin
                failed++;
                $display("FAIL ldq_counts[%0d]: got %h ldq=%0d want %h ldq=%0d", k,
                         dut_pack(), ldq_cnt_o, model_pack(), lit_ldq[k]);
            end
        end
    endtask

    task automatic test_rob_full();
        stim_t tab [$];
        logic [3:0] em;
        tab.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0));
        for (int j = 0; j < 7; j++)
            tab.push_back(mk(4'hF, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 15));
        tab.push_back(mk(4'h7, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 7));
        tab.push_back(mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 1));
        tab.push_back(mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 0));
        tab.push_back(mk(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1));
        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k]);
            @(negedge clock);
            em = model_mask();
            tests_run++;
            if (dispatch_mask_o !== em || dispatch_mask_o !== 4'(tab[k].lit_mask)) begin
                failed++;
                $display("FAIL rob_mask[%0d]: got %b want %b lit %0d", k,
                         dispatch_mask_o, em, tab[k].lit_mask);
            end
            @(posedge clock);
            model_tick(em);
            #1;
            tests_run++;
            if (dut_pack() !== model_pack()) begin
                failed++;
                $display("FAIL rob_counts[%0d]: got %h want %h", k, dut_pack(), model_pack());
            end
        end
        tests_run++;
        if (rob_cnt_o !== 6'd32) begin
            failed++;
            $display("FAIL rob_at_depth: got %0d want 32", rob_cnt_o);
        end
    endtask

    task automatic test_hole_and_stall();
        stim_t tab [$];
        logic [3:0] em;
        tab.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0));
        tab.push_back(mk(4'hB, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3));
        tab.push_back(mk(4'hF, 4'h9, 4'h1, 4'h2, 1'b1, 1'b0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 0));
        tab.push_back(mk(4'hF, 4'h0, 4'h3, 4'h3, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 15));
        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k]);
            @(negedge clock);
            em = model_mask();
            tests_run++;
            if (dispatch_mask_o !== em || dispatch_mask_o !== 4'(tab[k].lit_mask)) begin
                failed++;
                $display("FAIL hole_mask[%0d]: got %b want %b", k, dispatch_mask_o, em);
            end
            tests_run++;
            if (dispatch_frontend_stl_o !== model_stall(em) ||
                dispatch_num_o !== 3'($countones(em))) begin
                failed++;
                $display("FAIL hole_stall[%0d]: stall=%b num=%0d want %b/%0d", k,
                         dispatch_frontend_stl_o, dispatch_num_o, model_stall(em),
                         $countones(em));
            end
            @(posedge clock);
            model_tick(em);
            #1;
            tests_run++;
            if (dut_pack() !== model_pack()) begin
                failed++;
                $display("FAIL hole_counts[%0d]: got %h want %h", k, dut_pack(), model_pack());
            end
        end
    endtask

    task automatic test_underflow();
        stim_t tab [$];
        logic [3:0] em;
        tab.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0));
        tab.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1));
        tab.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 0));
        tab.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0));
        tab.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0));
        for (int k = 0; k < tab.size(); k++) begin
            apply(tab[k]);
            @(negedge clock);
            em = model_mask();
            tests_run++;
            if (dispatch_mask_o !== em) begin
                failed++;
                $display("FAIL uflow_mask[%0d]: got %b want %b", k, dispatch_mask_o, em);
            end
            @(posedge clock);
            model_tick(em);
            #1;
            tests_run++;
            if (dut_pack() !== model_pack()) begin
                failed++;
                $display("FAIL uflow_counts[%0d]: got %h want %h", k, dut_pack(), model_pack());
            end
        end
        tests_run++;
        if (credit_err_o !== 1'b1 || rs0_cnt_o !== 5'd0) begin
            failed++;
            $display("FAIL uflow_sticky: err=%b rs0=%0d want 1/0", credit_err_o, rs0_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] em;
        apply(mk(4'hF, 4'h6, 4'h1, 4'h4, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, -1));
        @(negedge clock);
        em = model_mask();
        @(posedge clock);
        model_tick(em);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (dut_pack() !== 25'd0 || dispatch_mask_o !== 4'h0 ||
            dispatch_frontend_stl_o !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: pack=%h mask=%b stall=%b want 0/0000/0",
                     dut_pack(), dispatch_mask_o, dispatch_frontend_stl_o);
        end
        idle();
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        logic [3:0] em;
        stim_t s;
        int    rr [5];
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < 5; r++) begin
                rr[r] = $urandom_range(0, (m_cnt[r] < 4) ? m_cnt[r] : 4);
                if ($urandom_range(0, 40) == 0) rr[r] = (m_cnt[r] < 6) ? m_cnt[r] + 1 : 7;
            end
            s = mk(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 24) == 0),
                   3'(rr[0]), 3'(rr[1]), 3'(rr[2]), 3'(rr[3]), 3'(rr[4]), -1);
            apply(s);
            @(negedge clock);
            em = model_mask();
            tests_run++;
            if (dispatch_mask_o !== em || dispatch_num_o !== 3'($countones(em)) ||
                dispatch_frontend_stl_o !== model_stall(em)) begin
                failed++;
                $display("FAIL rand_comb[%0d]: mask=%b num=%0d stall=%b want %b/%0d/%b", k,
                         dispatch_mask_o, dispatch_num_o, dispatch_frontend_stl_o,
                         em, $countones(em), model_stall(em));
            end
            @(posedge clock);
            model_tick(em);
            #1;
            tests_run++;
            if (dut_pack() !== model_pack()) begin
                failed++;
                $display("FAIL rand_counts[%0d]: got %h want %h", k, dut_pack(), model_pack());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_full_group();
        test_flush();
        test_ldq_partial();
        test_rob_full();
        test_hole_and_stall();
        test_underflow();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
